// File: rtl/pwm_driver.sv
// pwm_driver: 2^WIDTH-clock PWM, output high while the free-running counter is below the cutoff.
// Define PWM_DRIVER_SHADOW_UPDATE_EN to defer cutoff writes to the period boundary.
module pwm_driver #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             set_cutoff_en,
  input  logic [WIDTH-1:0] cutoff_value,
  output logic             pwm_out
);

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_active_cutoff;
  logic [WIDTH-1:0] w_active_next;
  logic             r_pwm;

`ifdef PWM_DRIVER_SHADOW_UPDATE_EN
  logic [WIDTH-1:0] r_pending_cutoff;
  logic             w_wrap;

  assign w_wrap = (r_cnt == '1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending_cutoff <= '0;
    end else if (set_cutoff_en) begin
      r_pending_cutoff <= cutoff_value;
    end
  end

  // A write landing on the wrap edge bypasses pending so it governs the very next period.
  always_comb begin
    w_active_next = r_active_cutoff;
    if (w_wrap) begin
      w_active_next = set_cutoff_en ? cutoff_value : r_pending_cutoff;
    end
  end
`else
  always_comb begin
    w_active_next = r_active_cutoff;
    if (set_cutoff_en) begin
      w_active_next = cutoff_value;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt           <= '0;
      r_active_cutoff <= '0;
      r_pwm           <= 1'b0;
    end else begin
      r_cnt           <= r_cnt + 1'b1;
      r_active_cutoff <= w_active_next;
      r_pwm           <= (r_cnt < r_active_cutoff);
    end
  end

  assign pwm_out = r_pwm;

endmodule

// File: tb/tb_pwm_driver.sv
// Scoreboard bench for pwm_driver: stimulus pushes expected per-edge output and period high counts.
module tb_pwm_driver;

  logic       clk;
  logic       reset_n;
  logic       set_cutoff_en;
  logic [7:0] cutoff_value;
  logic       pwm_out;

  typedef struct {
    bit exp;
    bit first;
    bit last;
    int want;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  logic [7:0] m_cnt;
  logic [7:0] m_act;
  logic [7:0] m_pend;

  pwm_driver #(.WIDTH(8)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .set_cutoff_en(set_cutoff_en),
    .cutoff_value (cutoff_value),
    .pwm_out      (pwm_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare one expectation per edge, 1 time unit after the edge.
  int acc = 0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        exp_t it;
        it = q.pop_front();
        if (it.first) acc = 0;
        if (pwm_out === 1'b1) acc++;
        checks++;
        if (pwm_out !== it.exp) begin
          errors++;
          $display("FAIL pwm_bit t=%0t got %b want %b", $time, pwm_out, it.exp);
        end
        if (it.last && it.want >= 0) begin
          checks++;
          if (acc != it.want) begin
            errors++;
            $display("FAIL high_count t=%0t got %0d want %0d", $time, acc, it.want);
          end
        end
      end
    end
  end

  task automatic step(input bit e, input logic [7:0] v, input int want);
    exp_t it;
    set_cutoff_en = e;
    cutoff_value  = v;
    it.exp = 1'b0; it.first = 1'b0; it.last = 1'b0; it.want = -1;
    if (!reset_n) begin
      m_cnt = '0; m_act = '0; m_pend = '0;
    end else begin
      it.exp   = (m_cnt < m_act);
      it.first = (m_cnt == 8'd0);
      it.last  = (m_cnt == 8'd255);
      it.want  = it.last ? want : -1;
`ifdef PWM_DRIVER_SHADOW_UPDATE_EN
      if (m_cnt == 8'd255) m_act = e ? v : m_pend;
      if (e) m_pend = v;
`else
      if (e) m_act = v;
`endif
      m_cnt = m_cnt + 8'd1;
    end
    @(posedge clk);
    q.push_back(it);
    #2;
  endtask

  // Idle for n clocks; full periods that start inside the run are checked against want.
  task automatic run(input int n, input int want);
    bit seen0 = 1'b0;
    logic [7:0] xv;
    xv = 'x;
    for (int i = 0; i < n; i++) begin
      if (m_cnt == 8'd0) seen0 = 1'b1;
      step(1'b0, xv, seen0 ? want : -1);
    end
  endtask

  task automatic run_to(input logic [7:0] c);
    while (m_cnt != c) step(1'b0, 8'd0, -1);
  endtask

  initial begin
    int sweep [7] = '{2, 4, 8, 16, 32, 64, 128};
    reset_n = 1'b0; set_cutoff_en = 1'b0; cutoff_value = '0;
    m_cnt = '0; m_act = '0; m_pend = '0;
    #2;
    for (int i = 0; i < 3; i++) step(1'b1, 8'd99, -1);
    reset_n = 1'b1;

    step(1'b1, 8'd254, -1); run(600, 254);
    step(1'b1, 8'd1, -1);   run(600, 1);
    foreach (sweep[i]) begin
      step(1'b1, sweep[i][7:0], -1);
      run(600, sweep[i]);
    end
    step(1'b1, 8'd0, -1);   run(600, 0);
    step(1'b1, 8'd255, -1); run(600, 255);

    step(1'b1, 8'd30, -1); step(1'b1, 8'd40, -1); run(600, 40);
    for (int i = 0; i < 3; i++) step(1'b1, 8'd77, -1);
    run(600, 77);

    step(1'b1, 8'd10, -1); run(600, 10);
    run_to(8'd100);
    step(1'b1, 8'd200, -1); run(600, 200);
    run_to(8'd255);
    step(1'b1, 8'd90, -1); run(600, 90);

    run_to(8'd50);
    reset_n = 1'b0;
    m_cnt = '0; m_act = '0; m_pend = '0;
    #1;
    checks++;
    if (pwm_out !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got %b want 0", pwm_out);
    end
    step(1'b0, 8'd0, -1); step(1'b1, 8'd33, -1);
    reset_n = 1'b1;
    run(600, 0);
    step(1'b1, 8'd128, -1); run(600, 128);

    #10;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got %0d want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
